// File: rtl/bus_mux_reg.sv
// Registered shared-bus multiplexer. It selects one of NREG registers, DIN or G using one-hot
// enables, checks for bus conflicts, and keeps a saturating conflict counter.
module bus_mux_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8,
  parameter int unsigned SRCW  = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NREG*WIDTH-1:0] i_regs,
  input  logic [WIDTH-1:0]      i_din,
  input  logic [WIDTH-1:0]      i_aluout,
  input  logic [NREG-1:0]       i_rout,
  input  logic                  i_din_out,
  input  logic                  i_g_out,
  input  logic                  i_hold,
  input  logic                  i_clr_cnt,
  output logic [WIDTH-1:0]      o_buswires,
  output logic                  o_bus_valid,
  output logic [SRCW-1:0]       o_src_id,
  output logic                  o_conflict,
  output logic [CNTW-1:0]       o_conflict_cnt
);

  localparam int unsigned NSRC = NREG + 2;

  logic [NSRC-1:0]  w_en;
  logic             w_any;
  logic             w_multi;
  logic             w_single;
  logic [WIDTH-1:0] w_data;
  logic [SRCW-1:0]  w_id;

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [SRCW-1:0]  r_src;
  logic             r_conflict;
  logic [CNTW-1:0]  r_cnt;

  assign w_en = {i_g_out, i_din_out, i_rout};

  // Running "seen one" / "seen two" chain gives E==0, E==1 and E>=2 without a full popcount.
  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int k = 0; k < int'(NSRC); k++) begin
      w_multi = w_multi | (w_any & w_en[k]);
      w_any   = w_any | w_en[k];
    end
  end

  assign w_single = w_any & ~w_multi;

  // AND-OR selection. The value is only exact when w_single is set, and only then is it loaded.
  always_comb begin
    w_data = '0;
    w_id   = '0;
    for (int k = 0; k < int'(NREG); k++) begin
      w_data = w_data | ({WIDTH{w_en[k]}} & i_regs[k*WIDTH +: WIDTH]);
      w_id   = w_id | ({SRCW{w_en[k]}} & SRCW'(k));
    end
    w_data = w_data | ({WIDTH{i_din_out}} & i_din) | ({WIDTH{i_g_out}} & i_aluout);
    w_id   = w_id | ({SRCW{i_din_out}} & SRCW'(NREG)) | ({SRCW{i_g_out}} & SRCW'(NREG + 1));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bus      <= '0;
      r_valid    <= 1'b0;
      r_src      <= '0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_valid    <= 1'b0;
      r_conflict <= 1'b0;
      if (!i_hold) begin
        if (w_single) begin
          r_bus   <= w_data;
          r_src   <= w_id;
          r_valid <= 1'b1;
        end
        if (w_multi) begin
          r_conflict <= 1'b1;
        end
      end
      if (i_clr_cnt) begin
        r_cnt <= '0;
      end else if (!i_hold && w_multi && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  assign o_buswires     = r_bus;
  assign o_bus_valid    = r_valid;
  assign o_src_id       = r_src;
  assign o_conflict     = r_conflict;
  assign o_conflict_cnt = r_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed self-checking bench for bus_mux_reg. Each step applies inputs, waits one clock
// edge, and checks the registered outputs against hand-computed values.
module tb_bus_mux_reg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREG  = 8;
  localparam int unsigned SRCW  = 4;
  localparam int unsigned CNTW  = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREG*WIDTH-1:0] regs;
  logic [WIDTH-1:0]      din;
  logic [WIDTH-1:0]      aluout;
  logic [NREG-1:0]       rout;
  logic                  din_out;
  logic                  g_out;
  logic                  hold;
  logic                  clr_cnt;
  logic [WIDTH-1:0]      buswires;
  logic                  bus_valid;
  logic [SRCW-1:0]       src_id;
  logic                  conflict;
  logic [CNTW-1:0]       conflict_cnt;

  int tests = 0;
  int fails = 0;

  bus_mux_reg #(.WIDTH(WIDTH), .NREG(NREG), .SRCW(SRCW), .CNTW(CNTW)) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_regs        (regs),
    .i_din         (din),
    .i_aluout      (aluout),
    .i_rout        (rout),
    .i_din_out     (din_out),
    .i_g_out       (g_out),
    .i_hold        (hold),
    .i_clr_cnt     (clr_cnt),
    .o_buswires    (buswires),
    .o_bus_valid   (bus_valid),
    .o_src_id      (src_id),
    .o_conflict    (conflict),
    .o_conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] bus, input logic valid,
                         input logic [3:0] id, input logic conf, input logic [7:0] cnt);
    chk({tag, ".bus"}, 32'(buswires), 32'(bus));
    chk({tag, ".valid"}, 32'(bus_valid), 32'(valid));
    chk({tag, ".src"}, 32'(src_id), 32'(id));
    chk({tag, ".conflict"}, 32'(conflict), 32'(conf));
    chk({tag, ".cnt"}, 32'(conflict_cnt), 32'(cnt));
  endtask

  initial begin
    reset = 1'b1; regs = '0; din = '0; aluout = '0; rout = '0;
    din_out = 1'b0; g_out = 1'b0; hold = 1'b0; clr_cnt = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk_out("idle", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0);

    for (int k = 0; k < 8; k++) regs[k*16 +: 16] = 16'(16'h1111 * k);
    for (int k = 0; k < 8; k++) begin
      rout = 8'(1 << k);
      step();
      chk_out($sformatf("sweep%0d", k), 16'(16'h1111 * k), 1'b1, 4'(k), 1'b0, 8'd0);
    end

    rout = '0; din = 16'hBEEF; din_out = 1'b1;
    step();
    chk_out("din", 16'hBEEF, 1'b1, 4'd8, 1'b0, 8'd0);
    din_out = 1'b0; aluout = 16'h1234; g_out = 1'b1;
    step();
    chk_out("g", 16'h1234, 1'b1, 4'd9, 1'b0, 8'd0);
    g_out = 1'b0; din_out = 1'b1;
    step();
    chk_out("reload", 16'hBEEF, 1'b1, 4'd8, 1'b0, 8'd0);

    din_out = 1'b0; rout = 8'h04; g_out = 1'b1;
    step();
    chk_out("conf1", 16'hBEEF, 1'b0, 4'd8, 1'b1, 8'd1);
    rout = '0; g_out = 1'b0;
    step();
    chk_out("after_conf", 16'hBEEF, 1'b0, 4'd8, 1'b0, 8'd1);

    rout = 8'h04; g_out = 1'b1;
    repeat (300) step();
    chk_out("saturate", 16'hBEEF, 1'b0, 4'd8, 1'b1, 8'd255);

    clr_cnt = 1'b1;
    step();
    chk_out("clr_vs_inc", 16'hBEEF, 1'b0, 4'd8, 1'b1, 8'd0);
    clr_cnt = 1'b0;
    step();
    chk_out("conf_after_clr", 16'hBEEF, 1'b0, 4'd8, 1'b1, 8'd1);

    rout = 8'h01; g_out = 1'b0; hold = 1'b1;
    step();
    chk_out("hold_single", 16'hBEEF, 1'b0, 4'd8, 1'b0, 8'd1);
    rout = 8'h03;
    step();
    chk_out("hold_multi", 16'hBEEF, 1'b0, 4'd8, 1'b0, 8'd1);
    hold = 1'b0;

    rout = 8'h20;
    step();
    chk_out("reg5", 16'h5555, 1'b1, 4'd5, 1'b0, 8'd1);
    rout = '0; regs[5*16 +: 16] = 16'hAAAA;
    step();
    chk_out("sampled", 16'h5555, 1'b0, 4'd5, 1'b0, 8'd1);

    rout = 8'h02; reset = 1'b1;
    step();
    chk_out("reset_mid", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0);
    reset = 1'b0; rout = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
